// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction unit: counter encodings,
// instruction size and the immediate-to-byte-offset helper.
package bpu_pkg;

  localparam int unsigned INSN_BYTES = 4;
  localparam int unsigned MAX_W      = 64;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Sign-extend an imm_w-bit word offset held in a MAX_W container, then scale to bytes.
  function automatic logic [MAX_W-1:0] sext_shift(input logic [MAX_W-1:0] imm,
                                                  input int unsigned      imm_w);
    logic signed [MAX_W-1:0] s;
    s = $signed(imm << (MAX_W - imm_w)) >>> (MAX_W - imm_w);
    return $unsigned(s) << 2;
  endfunction

  // Two-bit saturating counter step toward the resolved direction.
  function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic taken);
    logic [1:0] n;
    n = c;
    if (taken && (c != ST)) n = c + 2'(1);
    else if (!taken && (c != SNT)) n = c - 2'(1);
    return n;
  endfunction

endpackage

// File: rtl/branch_pred_unit_if.sv
// Lookup, resolve and prediction/redirect signals of the branch prediction unit.
interface branch_pred_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned CNT_W  = 16
);
  logic              lk_valid;
  logic [ADDR_W-1:0] lk_pc;
  logic [IMM_W-1:0]  lk_imm;
  logic              pred_valid;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              res_valid;
  logic [ADDR_W-1:0] res_pc;
  logic [IMM_W-1:0]  res_imm;
  logic              res_taken;
  logic              res_pred_taken;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  mispredict_cnt;

  modport master (
    output lk_valid, lk_pc, lk_imm,
    output res_valid, res_pc, res_imm, res_taken, res_pred_taken,
    input  pred_valid, pred_taken, pred_target,
    input  mispredict, redirect_pc, mispredict_cnt
  );

  modport slave (
    input  lk_valid, lk_pc, lk_imm,
    input  res_valid, res_pc, res_imm, res_taken, res_pred_taken,
    output pred_valid, pred_taken, pred_target,
    output mispredict, redirect_pc, mispredict_cnt
  );
endinterface

// File: rtl/branch_tgt_calc.sv
// Combinational branch target (pc + 4 + sext(imm) << 2) and fall-through (pc + 4).
module branch_tgt_calc
  import bpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IMM_W  = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [IMM_W-1:0]  imm,
  output logic [ADDR_W-1:0] fall_thru_c,
  output logic [ADDR_W-1:0] tgt_c
);

  assign fall_thru_c = pc + ADDR_W'(INSN_BYTES);
  assign tgt_c       = fall_thru_c + ADDR_W'(sext_shift(MAX_W'(imm), IMM_W));

endmodule

// File: rtl/branch_pred_unit.sv
// Branch direction predictor (2-bit counter table) with target computation,
// resolve-time training, mispredict redirect and saturating mispredict count.
module branch_pred_unit
  import bpu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned IMM_W     = 16,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned CNT_W     = 16
) (
  input logic               clk,
  input logic               rst,
  branch_pred_unit_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]        bht [BHT_DEPTH];
  logic [IDX_W-1:0]  lk_idx;
  logic [IDX_W-1:0]  res_idx;
  logic [ADDR_W-1:0] lk_ft_c, lk_tgt_c, res_ft_c, res_tgt_c;
  logic              mispredict_c;

  logic              pred_valid_q;
  logic              pred_taken_q;
  logic [ADDR_W-1:0] pred_target_q;
  logic              mispredict_q;
  logic [ADDR_W-1:0] redirect_pc_q;
  logic [CNT_W-1:0]  mispredict_cnt_q;

  assign lk_idx       = bus.lk_pc[IDX_W+1:2];
  assign res_idx      = bus.res_pc[IDX_W+1:2];
  assign mispredict_c = bus.res_valid && (bus.res_taken != bus.res_pred_taken);

  branch_tgt_calc #(.ADDR_W(ADDR_W), .IMM_W(IMM_W)) u_lk_tgt (
    .pc          (bus.lk_pc),
    .imm         (bus.lk_imm),
    .fall_thru_c (lk_ft_c),
    .tgt_c       (lk_tgt_c)
  );

  branch_tgt_calc #(.ADDR_W(ADDR_W), .IMM_W(IMM_W)) u_res_tgt (
    .pc          (bus.res_pc),
    .imm         (bus.res_imm),
    .fall_thru_c (res_ft_c),
    .tgt_c       (res_tgt_c)
  );

  // Lookup reads the pre-update counter; a same-cycle resolve lands on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) bht[i] <= WNT;
      pred_valid_q     <= 1'b0;
      pred_taken_q     <= 1'b0;
      pred_target_q    <= '0;
      mispredict_q     <= 1'b0;
      redirect_pc_q    <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      pred_valid_q <= bus.lk_valid;
      if (bus.lk_valid) begin
        pred_taken_q  <= bht[lk_idx][1];
        pred_target_q <= bht[lk_idx][1] ? lk_tgt_c : lk_ft_c;
      end
      if (bus.res_valid) bht[res_idx] <= cnt_next(bht[res_idx], bus.res_taken);
      mispredict_q <= mispredict_c;
      if (mispredict_c) begin
        redirect_pc_q <= bus.res_taken ? res_tgt_c : res_ft_c;
        if (mispredict_cnt_q != '1) mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.pred_valid     = pred_valid_q;
  assign bus.pred_taken     = pred_taken_q;
  assign bus.pred_target    = pred_target_q;
  assign bus.mispredict     = mispredict_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_pred_unit.sv
// Directed bench for branch_pred_unit; a second instance with a 2-bit
// mispredict counter shares the stimulus to exercise count saturation.
module tb_branch_pred_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_pred_unit_if #(.ADDR_W(32), .IMM_W(16), .CNT_W(16)) bus ();
  branch_pred_unit_if #(.ADDR_W(32), .IMM_W(16), .CNT_W(2))  bus2 ();

  branch_pred_unit #(.ADDR_W(32), .IMM_W(16), .BHT_DEPTH(64), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  branch_pred_unit #(.ADDR_W(32), .IMM_W(16), .BHT_DEPTH(64), .CNT_W(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  assign bus2.lk_valid       = bus.lk_valid;
  assign bus2.lk_pc          = bus.lk_pc;
  assign bus2.lk_imm         = bus.lk_imm;
  assign bus2.res_valid      = bus.res_valid;
  assign bus2.res_pc         = bus.res_pc;
  assign bus2.res_imm        = bus.res_imm;
  assign bus2.res_taken      = bus.res_taken;
  assign bus2.res_pred_taken = bus.res_pred_taken;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.lk_valid       = 1'b0;
    bus.res_valid      = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [15:0] imm);
    bus.lk_valid = 1'b1;
    bus.lk_pc    = pc;
    bus.lk_imm   = imm;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [15:0] imm,
                         input logic taken, input logic pred);
    bus.res_valid      = 1'b1;
    bus.res_pc         = pc;
    bus.res_imm        = imm;
    bus.res_taken      = taken;
    bus.res_pred_taken = pred;
  endtask

  initial begin
    rst = 1'b1;
    bus.lk_valid = 1'b0; bus.lk_pc = '0; bus.lk_imm = '0;
    bus.res_valid = 1'b0; bus.res_pc = '0; bus.res_imm = '0;
    bus.res_taken = 1'b0; bus.res_pred_taken = 1'b0;
    tick(); tick();
    check("rst_pred_valid", 32'(bus.pred_valid), 32'd0);
    check("rst_pred_taken", 32'(bus.pred_taken), 32'd0);
    check("rst_pred_target", bus.pred_target, 32'd0);
    check("rst_mispredict", 32'(bus.mispredict), 32'd0);
    check("rst_redirect", bus.redirect_pc, 32'd0);
    check("rst_cnt", 32'(bus.mispredict_cnt), 32'd0);
    rst = 1'b0;

    // Initial lookup from weak-NT: fall-through
    lookup(32'h40, 16'h000F); tick();
    check("lk1_valid", 32'(bus.pred_valid), 32'd1);
    check("lk1_taken", 32'(bus.pred_taken), 32'd0);
    check("lk1_target", bus.pred_target, 32'h44);
    idle(); tick();
    check("idle_valid", 32'(bus.pred_valid), 32'd0);
    check("idle_hold_target", bus.pred_target, 32'h44);

    // Mispredicted taken branch trains the counter to weak-T
    resolve(32'h40, 16'h000F, 1'b1, 1'b0); tick();
    check("res1_mispredict", 32'(bus.mispredict), 32'd1);
    check("res1_redirect", bus.redirect_pc, 32'h80);
    check("res1_cnt", 32'(bus.mispredict_cnt), 32'd1);
    idle(); lookup(32'h40, 16'h000F); tick();
    check("res1_pulse_end", 32'(bus.mispredict), 32'd0);
    check("lk2_taken", 32'(bus.pred_taken), 32'd1);
    check("lk2_target", bus.pred_target, 32'h80);

    // Same-index lookup and resolve: lookup sees pre-update counter
    idle(); lookup(32'h0, 16'h0001); resolve(32'h0, 16'h0001, 1'b1, 1'b1); tick();
    check("coll_taken", 32'(bus.pred_taken), 32'd0);
    check("coll_target", bus.pred_target, 32'h4);
    check("coll_no_mispredict", 32'(bus.mispredict), 32'd0);
    idle(); lookup(32'h0, 16'h0001); tick();
    check("coll_next_taken", 32'(bus.pred_taken), 32'd1);
    check("coll_next_target", bus.pred_target, 32'h8);

    // Negative offset: 0x100 + 4 - 4
    lookup(32'h100, 16'hFFFF); tick();
    check("neg_taken", 32'(bus.pred_taken), 32'd1);
    check("neg_target", bus.pred_target, 32'h100);

    // Address wrap on both resolve and lookup paths
    idle(); resolve(32'hFFFF_FFFC, 16'h0000, 1'b1, 1'b0); tick();
    check("wrap_redirect", bus.redirect_pc, 32'h0);
    check("wrap_cnt", 32'(bus.mispredict_cnt), 32'd2);
    idle(); lookup(32'hFFFF_FFFC, 16'h0000); tick();
    check("wrap_taken", 32'(bus.pred_taken), 32'd1);
    check("wrap_target", bus.pred_target, 32'h0);

    // Saturate at strong-T, then step down one at a time
    idle();
    for (int i = 0; i < 4; i++) begin
      resolve(32'h80, 16'h0002, 1'b1, 1'b1); tick();
    end
    idle(); lookup(32'h80, 16'h0002); tick();
    check("sat_st_taken", 32'(bus.pred_taken), 32'd1);
    idle(); resolve(32'h80, 16'h0002, 1'b0, 1'b1); tick();
    check("st_dn_mispredict", 32'(bus.mispredict), 32'd1);
    check("st_dn_redirect", bus.redirect_pc, 32'h84);
    check("st_dn_cnt2", 32'(bus2.mispredict_cnt), 32'd3);
    idle(); lookup(32'h80, 16'h0002); tick();
    check("wt_taken", 32'(bus.pred_taken), 32'd1);
    check("wt_target", bus.pred_target, 32'h8C);
    idle(); resolve(32'h80, 16'h0002, 1'b0, 1'b1); tick();
    idle(); lookup(32'h80, 16'h0002); tick();
    check("wnt_taken", 32'(bus.pred_taken), 32'd0);
    check("wnt_target", bus.pred_target, 32'h84);

    // Saturate at strong-NT: three NT then one T leaves weak-NT
    idle();
    for (int i = 0; i < 3; i++) begin
      resolve(32'hC0, 16'h0003, 1'b0, 1'b0); tick();
    end
    resolve(32'hC0, 16'h0003, 1'b1, 1'b0); tick();
    check("snt_mispredict", 32'(bus.mispredict), 32'd1);
    check("cnt_five", 32'(bus.mispredict_cnt), 32'd5);
    check("cnt2_sat", 32'(bus2.mispredict_cnt), 32'd3);
    idle(); lookup(32'hC0, 16'h0003); tick();
    check("snt_taken", 32'(bus.pred_taken), 32'd0);

    // Reset overrides concurrent lookup and mismatching resolve
    idle(); rst = 1'b1;
    lookup(32'h40, 16'h000F); resolve(32'h40, 16'h000F, 1'b1, 1'b0); tick();
    check("rst_ovr_mispredict", 32'(bus.mispredict), 32'd0);
    check("rst_ovr_cnt", 32'(bus.mispredict_cnt), 32'd0);
    check("rst_ovr_cnt2", 32'(bus2.mispredict_cnt), 32'd0);
    check("rst_ovr_valid", 32'(bus.pred_valid), 32'd0);
    rst = 1'b0; idle(); lookup(32'h40, 16'h000F); tick();
    check("rst_ovr_taken", 32'(bus.pred_taken), 32'd0);
    check("rst_ovr_target", bus.pred_target, 32'h44);
    idle(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_pred_unit.md
# branch_pred_unit

Parametrised branch target and direction predictor for the MIPS pipeline, successor to the single-cycle combinational branch adder. At fetch it computes the branch target from PC and 16-bit immediate and predicts direction from a table of 2-bit saturating counters. At resolve it trains the table and flags mispredictions with a redirect PC. Sits between the fetch PC register and the execute-stage branch comparator.

## Interface
- `ADDR_W`, 32, PC/address width
- `IMM_W`, 16, immediate width; sign-extended to `ADDR_W`
- `BHT_DEPTH`, 64, number of counters; power of two, ≥ 2
- `CNT_W`, 16, width of the mispredict statistics counter

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `lk_valid`  in  1  lookup request valid
- `lk_pc`  in  ADDR_W  PC of the branch being fetched
- `lk_imm`  in  IMM_W  branch immediate (word offset)
- `pred_valid`  out  1  registered lookup result valid
- `pred_taken`  out  1  predicted direction
- `pred_target`  out  ADDR_W  predicted next PC
- `res_valid`  in  1  resolve request valid
- `res_pc`  in  ADDR_W  PC of the resolved branch
- `res_imm`  in  IMM_W  immediate of the resolved branch
- `res_taken`  in  1  actual direction
- `res_pred_taken`  in  1  direction that was predicted for this branch
- `mispredict`  out  1  one-cycle pulse on a wrong prediction
- `redirect_pc`  out  ADDR_W  correct next PC; valid when `mispredict` = 1
- `mispredict_cnt`  out  CNT_W  saturating count of mispredictions

## Operation
- Target arithmetic: `tgt = pc + 4 + (sext(imm) << 2)`, modulo 2^ADDR_W. Wrap-around is silent. The fall-through PC is `pc + 4`, also modulo 2^ADDR_W.
- Index: `idx = pc[IDX_W+1:2]`, where `IDX_W = log2(BHT_DEPTH)`. PC bits [1:0] are ignored.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken when the MSB is 1.
- Lookup: the registered result gives `pred_taken = bht[idx][1]`. `pred_target` is `tgt` when the prediction is taken, otherwise `pc + 4`. When `lk_valid` = 0, `pred_valid` drops to 0 and the other pred outputs hold their last values.
- Resolve: on `res_valid`, increment `bht[idx]` if `res_taken`, otherwise decrement. The counter saturates at 11 and 00.
- Mispredict: asserted when `res_valid` and `res_taken` ≠ `res_pred_taken`. `redirect_pc` is `tgt` if `res_taken`, otherwise `pc + 4`. `mispredict_cnt` increments on each mispredict and saturates at all-ones.
- There is no FSM beyond the counter table. Lookup and resolve are fully independent and may both fire every cycle.

## Timing
- Lookup latency is 1 cycle: inputs at edge N produce `pred_*` after edge N+1.
- Resolve latency is 1 cycle: `mispredict` and `redirect_pc` appear after the next edge. The counter update is visible to lookups issued on the following cycle.
- Same-index collision (lookup and resolve in the same cycle): the lookup sees the pre-update counter (read-before-write). The update is still applied.
- Reset: every counter goes to 01, all outputs go to 0, and `mispredict_cnt` goes to 0.
- Reset mid-operation: asserting `rst` overrides any concurrent `lk_valid` or `res_valid`. No update is applied and no pulse is emitted that cycle.
- Throughput is one lookup and one resolve per cycle. There is no backpressure.

## Structure
- Shared package `bpu_pkg`:
  - counter encoding constants: `SNT`, `WNT`, `WT`, `ST`
  - `INSN_BYTES` = 4
  - the `sext_shift` target-function
- Sub-module `branch_tgt_calc`: combinational `pc + 4 + (sext(imm) << 2)`, parametrised by `ADDR_W` and `IMM_W`. It is instantiated twice, once for lookup and once for resolve.
- The counter table is a register array (not inferred RAM), so the one-cycle reset applies to every entry.

## Test plan
1. Reset, then lookup `pc=0x40`, `imm=0x000F` → `pred_valid=1`, `pred_taken=0`, `pred_target=0x44`.
2. Resolve `pc=0x40`, `imm=0x000F`, `taken=1`, `pred=0` → `mispredict=1`, `redirect_pc=0x80`, `mispredict_cnt=1`. Lookup `0x40` next cycle → `pred_taken=1`, `pred_target=0x80`.
3. Negative and wrap offsets:
   - `imm=0xFFFF`, `pc=0x100`, counter taken → target `0x100`
   - `pc=0xFFFFFFFC`, `imm=0`, taken → target `0x00000000`
4. Saturation:
   - four taken resolves at one index leave the counter at 11; one not-taken resolve gives 10, still predicting taken
   - `CNT_W=2` with 5 mispredicts → `mispredict_cnt=3`
5. Same-cycle lookup and resolve at index 0 from state 01 with `taken=1` → lookup returns not-taken; the lookup one cycle later returns taken.
6. Assert `rst` together with `res_valid` and a mismatch → no `mispredict` pulse. The counter stays 01 and `mispredict_cnt=0`.
